set_bit_index_streamer: RTL

- Expands a DATA_WIDTH-bit vector into a stream of the indices of its set bits, lowest index first, one index per cycle.
- Complements the positive-bit counter: the counter reduces a vector to how many bits are set; this block reports which bits are set.
- Sits in the continuous monitoring system between event/trigger capture vectors and the trace/packet formatter, which consumes one index per beat.

---
 rtl/set_bit_index_streamer_if.sv | 52 +++++
 rtl/set_bit_index_streamer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/set_bit_index_streamer_if.sv
// set_bit_index_streamer_if
// Bundles the vector-in / index-out handshake of set_bit_index_streamer.
// Optional feature macro: SET_BIT_STREAMER_ABORT_EN adds abort / done_aborted.
// "slave" is the streamer's own view; "master" is the view of whatever drives it.

interface set_bit_index_streamer_if #(
  parameter int DATA_WIDTH      = 1024,
  parameter int DATA_WIDTH_LOG2 = 10
);

  logic [DATA_WIDTH-1:0]      data_in;
  logic                       in_valid;
  logic                       in_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_WIDTH_LOG2-1:0] out_index;
  logic [DATA_WIDTH_LOG2:0]   out_seq;
  logic                       out_last;
  logic                       done;
  logic [DATA_WIDTH_LOG2:0]   done_count;
`ifdef SET_BIT_STREAMER_ABORT_EN
  logic                       abort;
  logic                       done_aborted;
`endif

`ifdef SET_BIT_STREAMER_ABORT_EN
  modport master (
    output data_in, in_valid, out_ready, abort,
    input  in_ready, out_valid, out_index, out_seq, out_last,
           done, done_count, done_aborted
  );

  modport slave (
    input  data_in, in_valid, out_ready, abort,
    output in_ready, out_valid, out_index, out_seq, out_last,
           done, done_count, done_aborted
  );
`else
  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, out_valid, out_index, out_seq, out_last,
           done, done_count
  );

  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, out_valid, out_index, out_seq, out_last,
           done, done_count
  );
`endif

endinterface

// File: rtl/set_bit_index_streamer.sv
// set_bit_index_streamer
// Expands a captured vector into a stream of its set-bit indices, lowest first,
// one per accepted beat, then pulses done with the number of beats delivered.
// Optional feature macro: SET_BIT_STREAMER_ABORT_EN (early stream termination).
// The done pulse trails the IDLE transition by one cycle so that the count and
// pulse leave from dedicated registers.

module set_bit_index_streamer #(
  parameter int DATA_WIDTH      = 1024,
  parameter int DATA_WIDTH_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  set_bit_index_streamer_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0]    MASK_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH_LOG2:0] CNT_ONE  = {{DATA_WIDTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                     state;
  state_t                     state_next;
  logic [DATA_WIDTH-1:0]      mask;
  logic [DATA_WIDTH-1:0]      mask_rest;
  logic [DATA_WIDTH_LOG2:0]   beat_cnt;
  logic [DATA_WIDTH_LOG2-1:0] low_index;
  logic                       one_left;
  logic                       in_fire;
  logic                       beat_fire;
  logic                       last_fire;
  logic                       fin_pend;
  logic [DATA_WIDTH_LOG2:0]   fin_count;
  logic                       done_q;
  logic [DATA_WIDTH_LOG2:0]   done_count_q;
`ifdef SET_BIT_STREAMER_ABORT_EN
  logic                       abort_hit;
  logic                       fin_abort;
  logic                       done_aborted_q;
`endif

  assign mask_rest = mask & (mask - MASK_ONE);
  assign one_left  = (mask != '0) && (mask_rest == '0);
  assign in_fire   = (state == IDLE) && bus.in_valid;
  assign beat_fire = (state == EMIT) && bus.out_ready;
  assign last_fire = beat_fire && one_left;
`ifdef SET_BIT_STREAMER_ABORT_EN
  assign abort_hit = (state == EMIT) && bus.abort;
`endif

  // Priority encoder: position of the lowest set bit still pending in the mask.
  always_comb begin
    low_index = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_index = DATA_WIDTH_LOG2'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: enter EMIT only for non-empty vectors, leave on last beat or abort.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_fire && (bus.data_in != '0)) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
`ifdef SET_BIT_STREAMER_ABORT_EN
        if (abort_hit || last_fire) begin
          state_next = IDLE;
        end
`else
        if (last_fire) begin
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Mask and beat counter: load on input accept, retire one bit per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask     <= '0;
      beat_cnt <= '0;
    end else if (in_fire) begin
      mask     <= bus.data_in;
      beat_cnt <= '0;
    end else if (beat_fire) begin
      mask     <= mask_rest;
      beat_cnt <= beat_cnt + CNT_ONE;
    end
  end

  // Finish capture: record that a vector ended and how many beats it delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_pend  <= 1'b0;
      fin_count <= '0;
`ifdef SET_BIT_STREAMER_ABORT_EN
      fin_abort <= 1'b0;
`endif
    end else begin
      fin_pend <= 1'b0;
      if (in_fire && (bus.data_in == '0)) begin
        fin_pend  <= 1'b1;
        fin_count <= '0;
`ifdef SET_BIT_STREAMER_ABORT_EN
        fin_abort <= 1'b0;
      end else if (abort_hit) begin
        fin_pend  <= 1'b1;
        fin_count <= beat_cnt + (bus.out_ready ? CNT_ONE : '0);
        fin_abort <= 1'b1;
`endif
      end else if (last_fire) begin
        fin_pend  <= 1'b1;
        fin_count <= beat_cnt + CNT_ONE;
`ifdef SET_BIT_STREAMER_ABORT_EN
        fin_abort <= 1'b0;
`endif
      end
    end
  end

  // Done pulse and held completion count, updated together one cycle after finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q       <= 1'b0;
      done_count_q <= '0;
`ifdef SET_BIT_STREAMER_ABORT_EN
      done_aborted_q <= 1'b0;
`endif
    end else begin
      done_q <= fin_pend;
      if (fin_pend) begin
        done_count_q <= fin_count;
`ifdef SET_BIT_STREAMER_ABORT_EN
        done_aborted_q <= fin_abort;
`endif
      end
    end
  end

  // Outputs decoded from the state register and datapath registers only.
  always_comb begin
    bus.in_ready   = (state == IDLE);
    bus.out_valid  = (state == EMIT);
    bus.out_index  = (state == EMIT) ? low_index : '0;
    bus.out_seq    = (state == EMIT) ? beat_cnt : '0;
    bus.out_last   = (state == EMIT) && one_left;
    bus.done       = done_q;
    bus.done_count = done_count_q;
`ifdef SET_BIT_STREAMER_ABORT_EN
    bus.done_aborted = done_aborted_q;
`endif
  end

endmodule
